// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-master I2C byte controller.
// bus_drive() maps FSM state and quarter phase to the open-drain pull-downs.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      ADDR_ACK,
      WR,
      WR_ACK,
      RD,
      RD_NACK,
      STOP
   } i2c_state_e;

   typedef enum logic [1:0] {
      Q0,
      Q1,
      Q2,
      Q3
   } qphase_e;

   localparam logic I2C_READ  = 1'b1;
   localparam logic I2C_WRITE = 1'b0;

   // Returns {scl_oe, sda_oe}; 1 pulls the line low. tx_bit is the bit being sent.
   function automatic logic [1:0] bus_drive(input i2c_state_e st, input qphase_e q,
                                            input logic tx_bit);
      logic scl_low;
      scl_low = (q == Q0) || (q == Q1);
      case (st)
         START:                         bus_drive = {q == Q3, (q == Q2) || (q == Q3)};
         ADDR, WR:                      bus_drive = {scl_low, ~tx_bit};
         ADDR_ACK, WR_ACK, RD, RD_NACK: bus_drive = {scl_low, 1'b0};
         STOP:                          bus_drive = {scl_low, q != Q3};
         default:                       bus_drive = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period tick generator: pulses once every CLK_DIV enabled, non-held cycles.
// clr_i restarts the period; hold_i freezes the count while a target stretches SCL.
module i2c_qtick #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic en_i,
   input  logic clr_i,
   input  logic hold_i,
   output logic tick_o
);

   localparam logic [7:0] LastCnt = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      tick_o = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !hold_i) begin
         if (cnt_q == LastCnt) begin
            cnt_d  = '0;
            tick_o = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/i2c_controller.sv
// Single-master I2C controller: one START, address byte, one data byte (write or read), STOP.
// Every bit is four quarters; all bus pull-downs come straight from flops.
module i2c_controller
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] addr,
   input  logic       rw,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       scl_in,
   input  logic       sda_in
);

   i2c_state_e state_q, state_d;
   qphase_e    qphase_q, qphase_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic       rx_bit_q, rx_bit_d;
   logic       rw_q, rw_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       ack_err_q, ack_err_d;
   logic       scl_oe_q, scl_oe_d;
   logic       sda_oe_q, sda_oe_d;

   logic accept, hold, tick, sample, eob;

   // A start coinciding with the done pulse is dropped, not queued.
   assign accept = start && !busy_q && !done_q;
   // Target stretching: SCL released by us but still sensed low.
   assign hold   = busy_q && !scl_oe_q && !scl_in && ((qphase_q == Q2) || (qphase_q == Q3));
   assign sample = tick && (qphase_q == Q2);
   assign eob    = tick && (qphase_q == Q3);

   i2c_qtick #(
      .CLK_DIV(CLK_DIV)
   ) u_qtick (
      .clk_i  (clk),
      .reset_i(reset),
      .en_i   (busy_q),
      .clr_i  (accept),
      .hold_i (hold),
      .tick_o (tick)
   );

   always_comb begin
      state_d   = state_q;
      qphase_d  = qphase_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      rx_bit_d  = rx_bit_q;
      rw_d      = rw_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ack_err_d = ack_err_q;

      if (tick) begin
         qphase_d = qphase_e'(qphase_q + 2'd1);
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = START;
               qphase_d  = Q0;
               bit_cnt_d = '0;
               busy_d    = 1'b1;
               ack_err_d = 1'b0;
               tx_d      = {addr, rw};
               rw_d      = rw;
               wdata_d   = wdata;
            end
         end
         START: begin
            if (eob) state_d = ADDR;
         end
         ADDR, WR: begin
            if (eob) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d   = (state_q == ADDR) ? ADDR_ACK : WR_ACK;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_d      = {tx_q[6:0], 1'b0};
               end
            end
         end
         ADDR_ACK: begin
            if (sample) rx_bit_d = sda_in;
            if (eob) begin
               if (rx_bit_q) begin
                  ack_err_d = 1'b1;
                  state_d   = STOP;
               end else if (rw_q == I2C_READ) begin
                  state_d = RD;
               end else begin
                  state_d = WR;
                  tx_d    = wdata_q;
               end
            end
         end
         WR_ACK: begin
            if (sample) rx_bit_d = sda_in;
            if (eob) begin
               if (rx_bit_q) ack_err_d = 1'b1;
               state_d = STOP;
            end
         end
         RD: begin
            if (sample) rx_d = {rx_q[6:0], sda_in};
            if (eob) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d   = RD_NACK;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         RD_NACK: begin
            if (eob) begin
               rdata_d = rx_q;
               state_d = STOP;
            end
         end
         STOP: begin
            if (eob) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Line drive is computed from next-state values so it is registered without lag.
      {scl_oe_d, sda_oe_d} = bus_drive(state_d, qphase_d, tx_d[7]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         qphase_q  <= Q0;
         bit_cnt_q <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         rx_bit_q  <= 1'b0;
         rw_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         scl_oe_q  <= 1'b0;
         sda_oe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         qphase_q  <= qphase_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         rx_bit_q  <= rx_bit_d;
         rw_q      <= rw_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         scl_oe_q  <= scl_oe_d;
         sda_oe_q  <= sda_oe_d;
      end
   end

   assign rdata   = rdata_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ack_err = ack_err_q;
   assign scl_oe  = scl_oe_q;
   assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_controller.sv
// Bench for i2c_controller: pulled-up bus with a byte-level target model, frame-level
// expectations (bits seen at SCL rising edges, latency, ack_err, rdata).
module tb_i2c_controller;

   localparam int unsigned CLK_DIV = 4;
   localparam int FullLat = 80 * CLK_DIV;
   localparam int NackLat = 44 * CLK_DIV;

   logic       clk = 1'b0;
   logic       reset, start, rw;
   logic [6:0] addr;
   logic [7:0] wdata, rdata;
   logic       busy, done, ack_err, scl_oe, sda_oe, scl_in, sda_in;

   int checks = 0;
   int failures = 0;
   longint cyc = 0;

   // Target configuration, written only by the test tasks.
   bit         target_present;
   logic [7:0] target_rdata;
   int         stretch_bit;
   logic [7:0] exp_rdata;

   // Bus monitor / target state, written only by the monitor process.
   logic        prev_scl, prev_sda;
   logic        slave_drive = 1'b0;
   int          stretch_left = 0;
   bit          stretch_done = 1'b0;
   int          cur_bit = -100;
   int          rel_len = 0;
   bit          start_seen = 1'b0;
   bit          stop_seen = 1'b0;
   logic        txn_rw = 1'b0;
   logic [31:0] obs_bits = '0;
   int          obs_n = 0;

   assign scl_in = !scl_oe && (stretch_left == 0);
   assign sda_in = !sda_oe && !slave_drive;

   i2c_controller #(
      .CLK_DIV(CLK_DIV)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .addr   (addr),
      .rw     (rw),
      .wdata  (wdata),
      .rdata  (rdata),
      .busy   (busy),
      .done   (done),
      .ack_err(ack_err),
      .scl_oe (scl_oe),
      .sda_oe (sda_oe),
      .scl_in (scl_in),
      .sda_in (sda_in)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Target: ACKs bit 8 (and bit 17 on writes), drives read data on bits 9..16.
   function automatic logic target_drive(input int idx);
      if (!target_present) return 1'b0;
      if (idx == 8) return 1'b1;
      if (idx >= 9 && idx <= 16 && txn_rw) return !target_rdata[16 - idx];
      if (idx == 17 && !txn_rw) return 1'b1;
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      logic scl_l, sda_l;
      if (stretch_left > 0) stretch_left = stretch_left - 1;
      if (stretch_bit >= 0 && !stretch_done && cur_bit == stretch_bit && scl_oe === 1'b0) begin
         stretch_left = 10;
         stretch_done = 1'b1;
      end
      scl_l = !scl_oe && (stretch_left == 0);
      sda_l = !sda_oe && !slave_drive;
      if (prev_scl === 1'b1 && scl_l === 1'b1 && prev_sda === 1'b1 && sda_l === 1'b0) begin
         start_seen   = 1'b1;
         stop_seen    = 1'b0;
         cur_bit      = -1;
         obs_bits     = '0;
         obs_n        = 0;
         rel_len      = 0;
         stretch_done = 1'b0;
      end else if (prev_scl === 1'b1 && scl_l === 1'b1 && prev_sda === 1'b0 && sda_l === 1'b1) begin
         stop_seen = 1'b1;
         cur_bit   = -100;
      end
      if (prev_scl === 1'b0 && scl_l === 1'b1) begin
         obs_bits = {obs_bits[30:0], sda_l};
         obs_n++;
         if (obs_n == 8) txn_rw = sda_l;
      end
      if (prev_scl === 1'b1 && scl_l === 1'b0 && cur_bit > -100) begin
         cur_bit++;
         slave_drive = target_drive(cur_bit);
      end
      if (stretch_bit >= 0 && cur_bit == stretch_bit && scl_oe === 1'b0) rel_len++;
      prev_scl = scl_l;
      prev_sda = sda_l;
   end

   // Expected SDA levels at each SCL rise: address byte, ACK slot, data byte, 9th slot, STOP.
   function automatic logic [31:0] frame_bits(input logic [6:0] a, input logic r,
                                              input logic [7:0] d, input bit present);
      if (!present) return {22'b0, a, r, 1'b1, 1'b0};
      // Ninth data slot: target ACK (0) on write, controller NACK (1) on read.
      return {13'b0, a, r, 1'b0, d, r, 1'b0};
   endfunction

   task automatic wait_done(input longint acc, output int lat);
      lat = -1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = int'(cyc - acc);
            break;
         end
      end
   endtask

   // Also releases reset in the same cycle start is raised.
   task automatic do_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                         input bit present, input logic [7:0] rd,
                         output logic acc_busy, output int lat);
      longint acc;
      target_present = present;
      target_rdata   = rd;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b1;
      addr  = a;
      rw    = r;
      wdata = wd;
      @(negedge clk);
      acc_busy = busy;
      acc      = cyc;
      start    = 1'b0;
      addr     = 7'($urandom);
      rw       = 1'($urandom);
      wdata    = 8'($urandom);
      wait_done(acc, lat);
   endtask

   task automatic test_reset();
      logic ab;
      int lat;
      logic [6:0] a;
      logic [7:0] d;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({scl_oe, sda_oe, busy, done, ack_err} !== 5'b0)
         $display("FAIL reset_ctrl got=%b exp=00000", {scl_oe, sda_oe, busy, done, ack_err});
      checks++;
      if (rdata !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", rdata);
      if (rdata !== 8'h00) failures++;
      if ({scl_oe, sda_oe, busy, done, ack_err} !== 5'b0) failures++;
      a = 7'($urandom);
      d = 8'($urandom);
      do_txn(a, 1'b0, d, 1'b1, 8'h00, ab, lat);
      checks++;
      if (ab !== 1'b1) begin
         $display("FAIL first_start_busy got=%b exp=1", ab);
         failures++;
      end
      checks++;
      if (lat != FullLat || obs_bits !== frame_bits(a, 1'b0, d, 1'b1)) begin
         $display("FAIL first_txn got lat=%0d bits=%h exp lat=%0d bits=%h", lat, obs_bits,
                  FullLat, frame_bits(a, 1'b0, d, 1'b1));
         failures++;
      end
   endtask

   task automatic test_write();
      logic ab;
      int lat;
      do_txn(7'h2A, 1'b0, 8'h67, 1'b1, 8'h00, ab, lat);
      checks++;
      if (obs_bits !== 32'b0101010_0_0_01100111_0_0 || obs_n != 19) begin
         $display("FAIL write_bits got=%b n=%0d exp=%b n=19", obs_bits, obs_n,
                  32'b0101010_0_0_01100111_0_0);
         failures++;
      end
      checks++;
      if (lat != FullLat) begin
         $display("FAIL write_latency got=%0d exp=%0d", lat, FullLat);
         failures++;
      end
      checks++;
      if (ack_err !== 1'b0 || stop_seen !== 1'b1) begin
         $display("FAIL write_status got ack_err=%b stop=%b exp 0 1", ack_err, stop_seen);
         failures++;
      end
   endtask

   task automatic test_read();
      logic ab;
      int lat;
      do_txn(7'h2A, 1'b1, 8'h00, 1'b1, 8'h55, ab, lat);
      exp_rdata = 8'h55;
      checks++;
      if (rdata !== 8'h55) begin
         $display("FAIL read_rdata got=%h exp=55", rdata);
         failures++;
      end
      checks++;
      if (obs_bits[1] !== 1'b1) begin
         $display("FAIL read_nack_slot got=%b exp=1", obs_bits[1]);
         failures++;
      end
      checks++;
      if (obs_bits !== frame_bits(7'h2A, 1'b1, 8'h55, 1'b1) || lat != FullLat || ack_err !== 1'b0)
      begin
         $display("FAIL read_frame got bits=%h lat=%0d ack_err=%b exp bits=%h lat=%0d ack_err=0",
                  obs_bits, lat, ack_err, frame_bits(7'h2A, 1'b1, 8'h55, 1'b1), FullLat);
         failures++;
      end
   endtask

   task automatic test_nack();
      logic ab;
      int lat;
      logic [6:0] a;
      a = 7'($urandom);
      do_txn(a, 1'b0, 8'hA5, 1'b0, 8'h00, ab, lat);
      checks++;
      if (ack_err !== 1'b1) begin
         $display("FAIL nack_ack_err got=%b exp=1", ack_err);
         failures++;
      end
      checks++;
      if (obs_n != 10 || obs_bits !== frame_bits(a, 1'b0, 8'hA5, 1'b0)) begin
         $display("FAIL nack_bits got=%h n=%0d exp=%h n=10", obs_bits, obs_n,
                  frame_bits(a, 1'b0, 8'hA5, 1'b0));
         failures++;
      end
      checks++;
      if (lat != NackLat || stop_seen !== 1'b1 || rdata !== exp_rdata) begin
         $display("FAIL nack_timing got lat=%0d stop=%b rdata=%h exp lat=%0d stop=1 rdata=%h",
                  lat, stop_seen, rdata, NackLat, exp_rdata);
         failures++;
      end
   endtask

   task automatic test_stretch();
      logic ab;
      int lat;
      logic [6:0] a;
      logic [7:0] d;
      a = 7'($urandom);
      d = 8'($urandom);
      stretch_bit = 3;
      do_txn(a, 1'b0, d, 1'b1, 8'h00, ab, lat);
      stretch_bit = -1;
      checks++;
      if (rel_len != 2 * CLK_DIV + 10) begin
         $display("FAIL stretch_high got=%0d exp=%0d", rel_len, 2 * CLK_DIV + 10);
         failures++;
      end
      checks++;
      if (lat != FullLat + 10 || obs_bits !== frame_bits(a, 1'b0, d, 1'b1) || ack_err !== 1'b0)
      begin
         $display("FAIL stretch_txn got lat=%0d bits=%h ack_err=%b exp lat=%0d bits=%h ack_err=0",
                  lat, obs_bits, ack_err, FullLat + 10, frame_bits(a, 1'b0, d, 1'b1));
         failures++;
      end
   endtask

   task automatic test_reset_mid();
      logic ab;
      int lat, n;
      logic [6:0] a;
      logic [7:0] d;
      target_present = 1'b1;
      @(negedge clk);
      start = 1'b1;
      addr  = 7'($urandom);
      rw    = 1'b0;
      wdata = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(cur_bit == 4 && scl_oe === 1'b1) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 1000) begin
         $display("FAIL reset_mid_reach got=timeout exp=addr_bit4");
         failures++;
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({scl_oe, sda_oe, busy, done} !== 4'b0000) begin
         $display("FAIL reset_mid_release got=%b exp=0000", {scl_oe, sda_oe, busy, done});
         failures++;
      end
      exp_rdata = 8'h00;
      @(negedge clk);
      checks++;
      if (stop_seen !== 1'b0 || done !== 1'b0 || rdata !== 8'h00) begin
         $display("FAIL reset_mid_nostop got stop=%b done=%b rdata=%h exp 0 0 00", stop_seen,
                  done, rdata);
         failures++;
      end
      a = 7'($urandom);
      d = 8'($urandom);
      do_txn(a, 1'b0, d, 1'b1, 8'h00, ab, lat);
      checks++;
      if (lat != FullLat || obs_bits !== frame_bits(a, 1'b0, d, 1'b1) || ack_err !== 1'b0) begin
         $display("FAIL reset_mid_after got lat=%0d bits=%h ack_err=%b exp lat=%0d bits=%h",
                  lat, obs_bits, ack_err, FullLat, frame_bits(a, 1'b0, d, 1'b1));
         failures++;
      end
   endtask

   task automatic test_overlap();
      logic [6:0] a1, a2;
      logic [7:0] d1, d2;
      longint acc;
      int lat;
      a1 = 7'($urandom);
      a2 = ~a1;
      d1 = 8'($urandom);
      d2 = ~d1;
      target_present = 1'b1;
      @(negedge clk);
      start = 1'b1;
      addr  = a1;
      rw    = 1'b0;
      wdata = d1;
      @(negedge clk);
      acc   = cyc;
      // start stays high with new operands for the whole transaction.
      addr  = a2;
      wdata = d2;
      wait_done(acc, lat);
      checks++;
      if (lat != FullLat || obs_bits !== frame_bits(a1, 1'b0, d1, 1'b1)) begin
         $display("FAIL overlap_first got lat=%0d bits=%h exp lat=%0d bits=%h", lat, obs_bits,
                  FullLat, frame_bits(a1, 1'b0, d1, 1'b1));
         failures++;
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         $display("FAIL overlap_done_cycle got busy=%b done=%b exp 0 0", busy, done);
         failures++;
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         $display("FAIL overlap_reaccept got busy=%b exp=1", busy);
         failures++;
      end
      acc   = cyc;
      start = 1'b0;
      wait_done(acc, lat);
      checks++;
      if (lat != FullLat || obs_bits !== frame_bits(a2, 1'b0, d2, 1'b1)) begin
         $display("FAIL overlap_second got lat=%0d bits=%h exp lat=%0d bits=%h", lat, obs_bits,
                  FullLat, frame_bits(a2, 1'b0, d2, 1'b1));
         failures++;
      end
   endtask

   task automatic test_random();
      logic ab, r;
      int lat, exp_lat;
      logic [6:0] a;
      logic [7:0] wd, rd;
      bit pr;
      for (int k = 0; k < 8; k++) begin
         a  = 7'($urandom);
         r  = 1'($urandom);
         wd = 8'($urandom);
         rd = 8'($urandom);
         pr = ($urandom_range(0, 3) != 0);
         do_txn(a, r, wd, pr, rd, ab, lat);
         if (pr && r) exp_rdata = rd;
         exp_lat = pr ? FullLat : NackLat;
         checks++;
         if (ab !== 1'b1 || lat != exp_lat) begin
            $display("FAIL rand_timing k=%0d got busy=%b lat=%0d exp busy=1 lat=%0d", k, ab, lat,
                     exp_lat);
            failures++;
         end
         checks++;
         if (obs_bits !== frame_bits(a, r, r ? rd : wd, pr)) begin
            $display("FAIL rand_bits k=%0d got=%h exp=%h", k, obs_bits,
                     frame_bits(a, r, r ? rd : wd, pr));
            failures++;
         end
         checks++;
         if (ack_err !== !pr || rdata !== exp_rdata) begin
            $display("FAIL rand_status k=%0d got ack_err=%b rdata=%h exp ack_err=%b rdata=%h", k,
                     ack_err, rdata, !pr, exp_rdata);
            failures++;
         end
      end
   endtask

   initial begin
      reset          = 1'b1;
      start          = 1'b0;
      addr           = '0;
      rw             = 1'b0;
      wdata          = '0;
      target_present = 1'b1;
      target_rdata   = '0;
      stretch_bit    = -1;
      exp_rdata      = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_nack();
      test_stretch();
      test_reset_mid();
      test_overlap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/i2c_controller.md
I2C_CONTROLLER -- requirements
Module: i2c_controller

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCL quarter-period (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a transaction request sampled only while busy=0.
REQ-005 The block SHALL have port addr, input, 7, the target address, captured with start.
REQ-006 The block SHALL have port rw, input, 1, where 1 is read and 0 is write, captured with start.
REQ-007 The block SHALL have port wdata, input, 8, the write byte, captured with start.
REQ-008 The block SHALL have port rdata, output, 8, the last byte read, held until the next read completes.
REQ-009 The block SHALL have port busy, output, 1, high from the cycle after start is accepted until done.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse at transaction end.
REQ-011 The block SHALL have port ack_err, output, 1, set with done if any ACK slot read 1, and held until the next start.
REQ-012 The block SHALL have ports scl_oe and sda_oe, outputs, 1 each, where 1 pulls the open-drain line low and 0 releases it.
REQ-013 The block SHALL have ports scl_in and sda_in, inputs, 1 each, the sensed bus levels (pulled-up lines).

Function
REQ-014 A quarter-tick generator SHALL pulse once every CLK_DIV clk cycles while busy, and SHALL be cleared on start acceptance.
REQ-015 Each bit-time SHALL be 4 quarters with this sequence:
  - Q0: SCL low, SDA updated.
  - Q1: SCL low.
  - Q2: SCL released.
  - Q3: SCL high.
REQ-016 Receive bits SHALL be sampled from sda_in on the final clk of Q2.
REQ-017 FSM states SHALL be IDLE, START, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_NACK, STOP.
REQ-018 START SHALL take 1 bit-time:
  - Q0–Q1: SDA and SCL released.
  - Q2: SDA pulled low while SCL is released.
  - Q3: SCL pulled low.
REQ-019 ADDR SHALL shift {addr,rw} MSB first, 8 bit-times.
REQ-020 ADDR_ACK SHALL release SDA and sample sda_in; 0 means ACK.
REQ-021 On ACK, the FSM SHALL go to WR if rw=0, else RD.
REQ-022 On NACK, the FSM SHALL set ack_err and go to STOP.
REQ-023 WR SHALL shift wdata MSB first, then go to WR_ACK, which samples ACK the same way as ADDR_ACK and then goes to STOP.
REQ-024 RD SHALL release SDA and sample 8 bits MSB first into a shift register, then go to RD_NACK.
REQ-025 RD_NACK SHALL release SDA (controller NACK) for 1 bit-time, then load rdata and go to STOP.
REQ-026 STOP SHALL take 1 bit-time:
  - Q0–Q1: SDA low, SCL low.
  - Q2: SCL released.
  - Q3: SDA released.
REQ-027 After STOP, the FSM SHALL pulse done, clear busy and return to IDLE.
REQ-028 A full transaction SHALL take 20 bit-times, which is 80*CLK_DIV clk cycles from start acceptance to done, excluding stretching.
REQ-029 Clock stretching: while scl_oe=0 and scl_in=0 during Q2/Q3, the quarter counter SHALL hold.
REQ-030 start asserted while busy=1 SHALL be ignored with no side effects.
REQ-031 start and done in the same cycle SHALL NOT begin a new transaction; start is re-sampled from the next cycle.
REQ-032 In IDLE, scl_oe and sda_oe SHALL both be 0.

Reset
REQ-033 While reset=1, on the next clk edge the block SHALL set:
  - state IDLE;
  - scl_oe=0, sda_oe=0;
  - busy=0, done=0, ack_err=0;
  - rdata=8'h00;
  - counters 0.
REQ-034 Reset mid-transaction SHALL release both lines immediately and SHALL NOT generate STOP.
REQ-035 The first start SHALL be accepted in the first cycle after reset deasserts.

Structure
REQ-036 Package i2c_pkg SHALL hold:
  - the FSM state enum;
  - constants I2C_READ=1 and I2C_WRITE=0;
  - quarter-phase encodings Q0..Q3.
REQ-037 Sub-module i2c_qtick SHALL implement the CLK_DIV quarter-tick counter with clear and hold (stretch) inputs.
REQ-038 All outputs SHALL be registered; no combinational path from inputs to scl_oe or sda_oe.

Verification
REQ-039 Write test: CLK_DIV=4, addr=0x2A, rw=0, wdata=0x67, target ACKs.
  - SDA at SCL high SHALL read 0,1,0,1,0,1,0,0 then ACK, then 0,1,1,0,0,1,1,1.
  - done SHALL pulse 320 clk after acceptance, with ack_err=0.
REQ-040 Read test: addr=0x2A, rw=1, bus model drives 0x55 MSB first.
  - rdata SHALL equal 0x55.
  - The controller SHALL leave SDA high in the 9th data slot.
  - ack_err SHALL be 0.
REQ-041 Address NACK test: no target on the bus (SDA stays 1).
  - ack_err SHALL be 1.
  - No data phase, STOP seen, done after 11 bit-times.
REQ-042 Stretch test: the model holds scl_in low 10 clk in bit 3 of ADDR.
  - That SCL high phase SHALL be extended by exactly 10 clk.
  - Data SHALL be intact.
REQ-043 Reset test: reset during ADDR bit 4.
  - The next cycle SHALL show scl_oe=0, sda_oe=0, busy=0, no done.
  - A following write SHALL complete normally.
REQ-044 Overlap test: start pulsed during busy, and start held through done.
  - SHALL be ignored until the cycle after done.
